// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the counter-width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int CNT_W(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/response bundle for serial_subtractor.
// The Ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [N-1:0] Diff;
    logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         Ovf;

    modport master (output start, A, B, Bin, input busy, done, Diff, Bout, Ovf);
    modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout, Ovf);
`else
    modport master (output start, A, B, Bin, input busy, done, Diff, Bout);
    modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout);
`endif
endinterface

// File: rtl/serial_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Purely combinational; the serial top reuses this single cell every cycle.
module full_subtractor_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~i_a & i_bin) | (i_b & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Start/busy/done handshake; results hold until the next completed operation.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int CW = CNT_W(N);

    ser_state_t    r_state;
    ser_state_t    w_next_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_res;
    logic          r_br;
    logic [N-1:0]  r_diff;
    logic          r_bout;

    logic          w_accept;
    logic          w_last;
    logic          w_d;
    logic          w_bout;
    logic [N-1:0]  w_res_next;

`ifdef SERIAL_SUB_OVF_EN
    logic          r_msb_a;
    logic          r_msb_b;
    logic          r_ovf;
`endif

    // A new request is taken whenever the unit is not mid-operation.
    assign w_accept   = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_state == SHIFT) && (r_cnt == CW'(N - 1));
    assign w_res_next = {w_d, r_res[N-1:1]};

    full_subtractor_bit u_bit (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_br),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: shift for N cycles, then present the result for one cycle.
    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next_state = SHIFT;
            SHIFT:   if (w_last)    w_next_state = DONE;
            DONE:    w_next_state = bus.start ? SHIFT : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operand capture on accept, then one bit processed per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_br  <= 1'b0;
            r_res <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_br  <= bus.Bin;
            r_res <= '0;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_bout;
            r_res <= w_res_next;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Result registers update only on the completing edge and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_bout;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits captured at accept; overflow registered with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msb_a <= 1'b0;
            r_msb_b <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_msb_a <= bus.A[N-1];
                r_msb_b <= bus.B[N-1];
            end
            if (w_last) begin
                // w_d is the result MSB on the final shift.
                r_ovf <= (r_msb_a ^ r_msb_b) & (r_msb_a ^ w_d);
            end
        end
    end

    assign bus.Ovf = r_ovf;
`endif

    assign bus.busy = (r_state == SHIFT);
    assign bus.done = (r_state == DONE);
    assign bus.Diff = r_diff;
    assign bus.Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=4).
// Stimulus pushes expected results into a queue; a monitor pops on each done pulse.
// Define SERIAL_SUB_OVF_EN for both bench and RTL to also check Ovf.
module tb_serial_subtractor;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    serial_subtractor_if #(.N(N)) bus ();

    serial_subtractor #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done cycle must correspond to a queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("diff", 32'(bus.Diff), 32'(e.diff));
                check("bout", 32'(bus.Bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(bus.Ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Issue one operation and measure busy length and accept-to-done latency.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                          input logic [N-1:0] e_diff, input logic e_bout, input logic e_ovf,
                          input string tag);
        int lat;
        int busy_cnt;
        sb_q.push_back('{e_diff, e_bout, e_ovf});
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(N));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(N));
    endtask

    initial begin
        int done_cnt;
        int done_at[$];

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_diff", 32'(bus.Diff), 0);
        check("rst_bout", 32'(bus.Bout), 0);

        // Directed vectors: a, b, bin -> diff, bout, ovf (hand-computed, modulo 16).
        run_op(4'd7, 4'd3, 1'b0, 4'd4,  1'b0, 1'b0, "t1");
        run_op(4'd3, 4'd7, 1'b0, 4'd12, 1'b1, 1'b0, "t2");
        run_op(4'd8, 4'd1, 1'b0, 4'd7,  1'b0, 1'b1, "t4");
        run_op(4'd5, 4'd4, 1'b1, 4'd0,  1'b0, 1'b0, "eq_bin");
        run_op(4'd4, 4'd4, 1'b1, 4'd15, 1'b1, 1'b0, "lt_bin");

        // Start held for 10 edges; operands change mid-op and must be ignored.
        sb_q.push_back('{4'd4, 1'b0, 1'b0});
        sb_q.push_back('{4'd7, 1'b0, 1'b1});
        @(negedge clk);
        bus.A     = 4'd7;
        bus.B     = 4'd3;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        done_cnt  = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            if (e == 1) begin
                #1;
                bus.A = 4'd10;
                bus.B = 4'd3;
            end
            if (e == 10) #1 bus.start = 1'b0;
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_at.push_back(e);
            end
            if (e == 7) check("t5_diff_held", 32'(bus.Diff), 4);
        end
        check("t5_done_count", 32'(done_cnt), 2);
        if (done_at.size() == 2) begin
            check("t5_first_done", 32'(done_at[0]), 5);
            check("t5_done_gap", 32'(done_at[1] - done_at[0]), 5);
        end

        run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, "t3");

        // Reset two shift edges into an operation aborts it.
        @(negedge clk);
        bus.A     = 4'd9;
        bus.B     = 4'd2;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_diff", 32'(bus.Diff), 0);
        check("abort_bout", 32'(bus.Bout), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(4'd9, 4'd2, 1'b0, 4'd7, 1'b0, 1'b1, "t6");

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
